display_scan: RTL and testbench
===============================

// Module: display_scan
//
// PURPOSE
//   Time-multiplexes N_DIGITS packed 3-bit values onto one shared 3-bit bus.
//   The bus feeds the 3-bit->7-segment decoder, which drives active-low segments
//   with bit 6 = segment a and bit 0 = segment g.
//   Drives one active-low anode per digit and inserts an all-off blanking interval
//   at each digit switch to suppress ghosting.
//   Double-buffers digit data so that displayed values change only on frame boundaries.
//
// PARAMETERS
//   N_DIGITS      4      number of multiplexed digits (>=1)
//   REFRESH_DIV   50000  clk cycles per digit slot (> BLANK_CYCLES)
//   BLANK_CYCLES  16     cycles at slot start with all anodes off (>=1)
//
// PORTS
//   clk         in   1             system clock, rising edge
//   rst_n       in   1             asynchronous active-low reset
//   digits_i    in   3*N_DIGITS    packed values, digit k = digits_i[3k+2:3k]
//   load_i      in   1             capture digits_i into shadow register this cycle
//   enable_i    in   1             1 = scan, 0 = display dark and counters held
//   number_o    out  3             value of current digit, to 7-seg decoder
//   anode_n_o   out  N_DIGITS      one-hot-low anode enable, bit k = digit k
//   frame_o     out  1             1-cycle pulse at each frame start
//
// BEHAVIOUR
//   Single clock domain. One reset:
//     - rst_n is asynchronous and active-low.
//     - Assertion takes effect immediately.
//     - Deassertion is synchronised externally.
//   Reset values:
//     - state=IDLE, slot_cnt=0, digit_idx=0.
//     - shadow=0, active=0, pending=0.
//     - number_o=3'd0, anode_n_o=all 1s, frame_o=0.
//   Storage:
//     - shadow and active registers, each 3*N_DIGITS bits.
//     - pending flag.
//     - slot_cnt, width $clog2(REFRESH_DIV).
//     - digit_idx, width $clog2(N_DIGITS) (min 1).
//   FSM states: IDLE, BLANK, ON.
//     - IDLE: anode_n_o all 1s; slot_cnt and digit_idx held at 0.
//       enable_i=1 -> BLANK on the next cycle, with frame_o pulsed (frame start).
//     - BLANK: anode_n_o all 1s.
//       -> ON when slot_cnt == BLANK_CYCLES-1.
//     - ON: anode_n_o[digit_idx]=0, all other bits 1.
//       When slot_cnt == REFRESH_DIV-1: slot_cnt<=0, digit_idx<=idx+1 (wraps N_DIGITS-1 -> 0), -> BLANK.
//     - Any state with enable_i=0 -> IDLE next cycle: outputs go dark, counters clear.
//       shadow and pending are retained.
//   Counting: slot_cnt increments every cycle in BLANK and ON and clears on the slot terminal.
//   Frame boundary, defined as either of:
//     - IDLE->BLANK;
//     - the ON terminal with digit_idx == N_DIGITS-1 (for N_DIGITS=1, every slot terminal).
//   At a frame boundary:
//     - frame_o=1 for exactly that cycle (registered, asserted the cycle after).
//     - If pending: active<=shadow, pending<=0.
//   Load:
//     - load_i=1: shadow<=digits_i, pending<=1.
//     - load_i coincident with a frame boundary: active<=digits_i directly, pending<=0.
//       The new data is shown in the frame that is starting.
//     - Repeated loads before a boundary: the last one wins.
//   Output timing:
//     - number_o = active[3*digit_idx +: 3], registered, updated the same cycle as anode_n_o.
//     - number_o is valid throughout BLANK, so the decoder settles before the anode enables.
//   Mid-operation reset: all state returns to reset values immediately; the first frame after reset shows zeros.
//   Widths: no arithmetic overflow; digit_idx wraps explicitly and never holds a value >= N_DIGITS.
//
// TESTING  (sim params N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
//   1. Reset: hold rst_n=0 with enable_i=1.
//      -> anode_n_o=4'b1111, number_o=0, frame_o=0.
//      Deassert rst_n -> first anode low appears 3 cycles later.
//   2. Scan order: load digits_i={3'd7,3'd5,3'd2,3'd1}, enable_i=1.
//      -> anode_n_o cycles 1110,1101,1011,0111.
//      Each anode is low 6 of every 8 cycles; number_o=1,2,5,7 respectively.
//      frame_o pulses every 32 cycles.
//   3. Double buffer: load 3'd3 into all digits mid-frame while digit 1 is lit.
//      -> number_o keeps old values until the next frame_o, then shows 3 for all digits.
//   4. Coincident: assert load_i on the frame-boundary cycle.
//      -> digit 0 of the new frame shows the new value; no extra frame of delay.
//   5. Disable: drop enable_i during ON.
//      -> anode_n_o=1111 next cycle.
//      Re-enable -> frame_o pulses and scan restarts at digit 0 with BLANK.
//   6. Async reset mid-slot: pulse rst_n low for less than one clk period.
//      -> outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/display_scan_if.sv
// Bus between a display data source and the display_scan multiplexer.
// The master supplies digit data and control; the slave returns the
// multiplexed digit value, anode enables and the frame pulse.
interface display_scan_if #(
  parameter int N_DIGITS = 4
);
  logic [3*N_DIGITS-1:0] digits_i;
  logic                  load_i;
  logic                  enable_i;
  logic [2:0]            number_o;
  logic [N_DIGITS-1:0]   anode_n_o;
  logic                  frame_o;

  modport master (
    output digits_i, load_i, enable_i,
    input  number_o, anode_n_o, frame_o
  );

  modport slave (
    input  digits_i, load_i, enable_i,
    output number_o, anode_n_o, frame_o
  );
endinterface

// File: rtl/display_scan.sv
// Multiplexed digit scanner: one shared 3-bit value bus, one active-low anode
// per digit, a blanking interval at each digit switch, and double-buffered
// digit data that only changes on frame boundaries.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | disabled, display dark, counters held at zero
//   BLANK | start of a digit slot, all anodes off, number_o settling
//   ON    | current digit's anode driven low until the slot terminal
module display_scan #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input logic          clk,
  input logic          rst_n,
  display_scan_if.slave bus
);

  localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DW = 3 * N_DIGITS;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] slot_cnt;
  logic [IW-1:0] digit_idx;
  logic [DW-1:0] shadow;
  logic [DW-1:0] active;
  logic          pending;

  logic          slot_term;
  logic          frame_start;
  logic [IW-1:0] idx_next;
  logic [DW-1:0] active_nxt;
  logic [2:0]    num_next;
  logic [N_DIGITS-1:0] anode_on;

  // Slot terminal, frame boundary detection and the data that the next
  // displayed digit will be taken from (a coincident load bypasses shadow).
  always_comb begin
    slot_term   = (state == ON) && (slot_cnt == SLOT_LAST);
    idx_next    = (digit_idx == IDX_LAST) ? '0 : digit_idx + IW'(1);
    frame_start = bus.enable_i &&
                  ((state == IDLE) || (slot_term && (digit_idx == IDX_LAST)));
    active_nxt  = active;
    if (frame_start) begin
      if (bus.load_i)   active_nxt = bus.digits_i;
      else if (pending) active_nxt = shadow;
    end
    num_next = active_nxt[3*idx_next +: 3];
    anode_on = ~(N_DIGITS'(1) << digit_idx);
  end

  // Scan FSM with registered outputs, slot/digit counters and data buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      slot_cnt      <= '0;
      digit_idx     <= '0;
      shadow        <= '0;
      active        <= '0;
      pending       <= 1'b0;
      bus.number_o  <= 3'd0;
      bus.anode_n_o <= '1;
      bus.frame_o   <= 1'b0;
    end else begin
      bus.frame_o <= 1'b0;
      active      <= active_nxt;

      if (bus.load_i) begin
        shadow  <= bus.digits_i;
        pending <= !frame_start;
      end else if (frame_start) begin
        pending <= 1'b0;
      end

      if (!bus.enable_i) begin
        state         <= IDLE;
        slot_cnt      <= '0;
        digit_idx     <= '0;
        bus.anode_n_o <= '1;
        bus.number_o  <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            state         <= BLANK;
            slot_cnt      <= '0;
            digit_idx     <= '0;
            bus.anode_n_o <= '1;
            bus.number_o  <= active_nxt[2:0];
            bus.frame_o   <= 1'b1;
          end
          BLANK: begin
            slot_cnt <= slot_cnt + SW'(1);
            if (slot_cnt == BLANK_LAST) begin
              state         <= ON;
              bus.anode_n_o <= anode_on;
            end
          end
          ON: begin
            if (slot_term) begin
              state         <= BLANK;
              slot_cnt      <= '0;
              digit_idx     <= idx_next;
              bus.anode_n_o <= '1;
              bus.number_o  <= num_next;
              bus.frame_o   <= frame_start;
            end else begin
              slot_cnt <= slot_cnt + SW'(1);
            end
          end
          default: begin
            state         <= IDLE;
            bus.anode_n_o <= '1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with N_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2. Inputs change and outputs are sampled on the falling edge;
// cyc counts falling edges after the first reset release.
module tb_display_scan;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cyc;

  display_scan_if #(.N_DIGITS(4)) bus ();

  display_scan #(
    .N_DIGITS(4),
    .REFRESH_DIV(8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int s);
    while (cyc < s) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an, input logic [2:0] num,
                         input logic fr);
    chk({tag, ".anode"},  32'(bus.anode_n_o), 32'(an));
    chk({tag, ".number"}, 32'(bus.number_o),  32'(num));
    chk({tag, ".frame"},  32'(bus.frame_o),   32'(fr));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rst_n        = 1'b0;
    bus.enable_i = 1'b1;
    bus.load_i   = 1'b0;
    bus.digits_i = 12'h000;

    // 1. reset held with enable high
    repeat (3) @(negedge clk);
    chk_out("reset", 4'b1111, 3'd0, 1'b0);

    // 2. release reset with a coincident load of {7,5,2,1}
    rst_n        = 1'b1;
    bus.load_i   = 1'b1;
    bus.digits_i = {3'd7, 3'd5, 3'd2, 3'd1};
    goto(1);
    bus.load_i = 1'b0;
    chk_out("start_frame", 4'b1111, 3'd1, 1'b1);
    goto(2);
    chk_out("blank0", 4'b1111, 3'd1, 1'b0);
    goto(3);
    chk_out("on_d0", 4'b1110, 3'd1, 1'b0);
    goto(8);
    chk("on_d0_last", 32'(bus.anode_n_o), 32'h0000000e);
    goto(9);
    chk_out("blank_d1", 4'b1111, 3'd2, 1'b0);
    goto(11);
    chk_out("on_d1", 4'b1101, 3'd2, 1'b0);
    goto(19);
    chk_out("on_d2", 4'b1011, 3'd5, 1'b0);
    goto(27);
    chk_out("on_d3", 4'b0111, 3'd7, 1'b0);
    goto(32);
    chk("frame_low", 32'(bus.frame_o), 32'd0);
    goto(33);
    chk_out("frame2", 4'b1111, 3'd1, 1'b1);

    // 3. mid-frame load of all 3s while digit 1 is lit
    goto(44);
    chk_out("d1_lit", 4'b1101, 3'd2, 1'b0);
    bus.load_i   = 1'b1;
    bus.digits_i = {3'd3, 3'd3, 3'd3, 3'd3};
    goto(45);
    bus.load_i = 1'b0;
    chk("held_d1", 32'(bus.number_o), 32'd2);
    goto(51);
    chk_out("held_d2", 4'b1011, 3'd5, 1'b0);
    goto(59);
    chk_out("held_d3", 4'b0111, 3'd7, 1'b0);
    goto(65);
    chk_out("frame3", 4'b1111, 3'd3, 1'b1);
    goto(67);
    chk_out("new_d0", 4'b1110, 3'd3, 1'b0);
    goto(75);
    chk_out("new_d1", 4'b1101, 3'd3, 1'b0);

    // 4. load coincident with the frame boundary at the edge after cyc 96
    goto(96);
    chk_out("pre_bound", 4'b0111, 3'd3, 1'b0);
    bus.load_i   = 1'b1;
    bus.digits_i = {3'd4, 3'd6, 3'd0, 3'd5};
    goto(97);
    bus.load_i = 1'b0;
    chk_out("coinc_frame", 4'b1111, 3'd5, 1'b1);
    goto(99);
    chk_out("coinc_d0", 4'b1110, 3'd5, 1'b0);

    // 5. disable during ON, then re-enable
    goto(100);
    bus.enable_i = 1'b0;
    goto(101);
    chk_out("disabled", 4'b1111, 3'd0, 1'b0);
    goto(103);
    chk("disabled_hold", 32'(bus.anode_n_o), 32'h0000000f);
    bus.enable_i = 1'b1;
    goto(104);
    chk_out("reenable", 4'b1111, 3'd5, 1'b1);
    goto(105);
    chk("reen_blank", 32'(bus.anode_n_o), 32'h0000000f);
    goto(106);
    chk_out("reen_d0", 4'b1110, 3'd5, 1'b0);

    // 6. asynchronous reset pulse shorter than a clock period
    goto(108);
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 4'b1111, 3'd0, 1'b0);
    #1 rst_n = 1'b1;
    goto(109);
    chk_out("post_rst_frame", 4'b1111, 3'd0, 1'b1);
    goto(111);
    chk_out("post_rst_d0", 4'b1110, 3'd0, 1'b0);
    goto(119);
    chk_out("post_rst_d1", 4'b1101, 3'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
